// File: rtl/pipelined_subtractor.sv
// Pipelined subtractor: diff = a - b - b_in, resolved one SLICE per stage.
// An input register captures accepted operands. Each following stage resolves
// one slice and registers that slice's borrow. The stage also forwards the
// unconsumed upper operand bits and the lower diff bits already resolved.
// The pipeline moves as a whole and freezes while the output is held.
module pipelined_subtractor #(
  parameter int  WIDTH  = 64,
  parameter int  SLICE  = 16,
  localparam int STAGES = WIDTH / SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             zero
);

  logic             stall;
  logic             advance;
  logic             in_valid_reg;
  logic             in_borrow_reg;
  logic [WIDTH-1:0] in_a_reg;
  logic [WIDTH-1:0] in_b_reg;

  assign stall    = out_valid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = advance;

  // Operand capture. A bubble loads zeros, so idle cycles never leave stale
  // data or flags on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_reg  <= 1'b0;
      in_a_reg      <= '0;
      in_b_reg      <= '0;
      in_borrow_reg <= 1'b0;
    end else if (advance) begin
      in_valid_reg  <= in_valid;
      in_a_reg      <= in_valid ? a : '0;
      in_b_reg      <= in_valid ? b : '0;
      in_borrow_reg <= in_valid & b_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : stage
      // Operand bits still to be consumed, starting with this stage's slice.
      localparam int REM_W = WIDTH - gi * SLICE;
      // Diff bits known once this stage has registered its result.
      localparam int LO_W  = (gi + 1) * SLICE;

      logic [REM_W-1:0] a_rem;
      logic [REM_W-1:0] b_rem;
      logic             borrow_src;
      logic             valid_src;
      logic [SLICE:0]   slice_sub;
      logic [LO_W-1:0]  diff_next;
      logic             valid_reg;
      logic             borrow_reg;
      logic [LO_W-1:0]  diff_reg;

      if (gi == 0) begin : src
        assign a_rem      = in_a_reg;
        assign b_rem      = in_b_reg;
        assign borrow_src = in_borrow_reg;
        assign valid_src  = in_valid_reg;
        assign diff_next  = slice_sub[SLICE-1:0];
      end else begin : src
        assign a_rem      = stage[gi-1].carry.a_hi_reg;
        assign b_rem      = stage[gi-1].carry.b_hi_reg;
        assign borrow_src = stage[gi-1].borrow_reg;
        assign valid_src  = stage[gi-1].valid_reg;
        assign diff_next  = {slice_sub[SLICE-1:0], stage[gi-1].diff_reg};
      end

      // The extra top bit of the widened difference is this slice's borrow-out.
      assign slice_sub = {1'b0, a_rem[SLICE-1:0]}
                       - {1'b0, b_rem[SLICE-1:0]}
                       - {{SLICE{1'b0}}, borrow_src};

      // Register the partial result, borrow and valid. All of them hold during a stall.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg  <= 1'b0;
          borrow_reg <= 1'b0;
          diff_reg   <= '0;
        end else if (advance) begin
          valid_reg  <= valid_src;
          borrow_reg <= slice_sub[SLICE];
          diff_reg   <= diff_next;
        end
      end

      if (gi < STAGES - 1) begin : carry
        localparam int HI_W = WIDTH - LO_W;
        logic [HI_W-1:0] a_hi_reg;
        logic [HI_W-1:0] b_hi_reg;

        // Forward the upper operand bits that later stages still need.
        always_ff @(posedge clk) begin
          if (rst) begin
            a_hi_reg <= '0;
            b_hi_reg <= '0;
          end else if (advance) begin
            a_hi_reg <= a_rem[REM_W-1:SLICE];
            b_hi_reg <= b_rem[REM_W-1:SLICE];
          end
        end
      end

      if (gi == STAGES - 1) begin : flags
        logic ovf_next;
        logic zero_next;
        logic ovf_reg;
        logic zero_reg;

        // The last slice holds the operand MSBs, so the overflow check can read them here.
        assign ovf_next  = valid_src
                         & (a_rem[SLICE-1] != b_rem[SLICE-1])
                         & (slice_sub[SLICE-1] != a_rem[SLICE-1]);
        assign zero_next = valid_src & (diff_next == '0);

        // Register the result flags together with the final diff.
        always_ff @(posedge clk) begin
          if (rst) begin
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
          end else if (advance) begin
            ovf_reg  <= ovf_next;
            zero_reg <= zero_next;
          end
        end
      end
    end
  endgenerate

  assign out_valid = stage[STAGES-1].valid_reg;
  assign diff      = stage[STAGES-1].diff_reg;
  assign b_out     = stage[STAGES-1].borrow_reg;
  assign ovf       = stage[STAGES-1].flags.ovf_reg;
  assign zero      = stage[STAGES-1].flags.zero_reg;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Self-checking bench for pipelined_subtractor. It uses a table of directed
// vectors, a scoreboard of expected results, and hand-written sequences for
// latency, backpressure and mid-flight reset.
module tb_pipelined_subtractor;
  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             ovf;
  logic             zero;

  pipelined_subtractor #(.WIDTH(WIDTH), .SLICE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [63:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   checks       = 0;
  int   errors       = 0;
  int   stall_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%h required 0x%h", name, act, req);
    end
  endtask

  // Reference: full-width subtraction with one extra bit for the borrow.
  function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv,
                                 input logic bi, input int id);
    logic [64:0] full;
    exp_t        e;
    full   = {1'b0, av} - {1'b0, bv} - {64'd0, bi};
    e.diff = full[63:0];
    e.bout = full[64];
    e.ovf  = (av[63] != bv[63]) && (full[63] != av[63]);
    e.zero = (full[63:0] == 64'd0);
    e.id   = id;
    return e;
  endfunction

  // Start at posedge+1. Hold the operand until the next edge accepts it, then
  // push the expected result. Return at posedge+1 after that edge.
  task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic bi, input exp_t e);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    b_in     = bi;
    forever begin
      @(negedge clk);
      if (in_ready || guard >= 60) break;
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles required 1 (id %0d)", guard, e.id);
      @(posedge clk);
    end else begin
      @(posedge clk);
      sb.push_back(e);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    check("drain_pending", 64'(sb.size()), 64'd0);
    sb.delete();
    #1;
  endtask

  // Output monitor: pop and compare each consumed result, and verify that outputs
  // hold during stalls.
  initial begin
    exp_t        e;
    logic        prev_stall;
    logic [63:0] prev_diff;
    logic [2:0]  prev_flags;
    prev_stall = 1'b0;
    prev_diff  = '0;
    prev_flags = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_diff", diff, prev_diff);
          check("hold_flags", 64'({b_out, ovf, zero}), 64'(prev_flags));
        end
        if (out_valid && !out_ready) begin
          stall_cycles++;
          check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got diff=0x%h required no result", diff);
          end else begin
            e = sb.pop_front();
            $display("OUT id=%0d diff=0x%h b_out=%0b ovf=%0b zero=%0b", e.id, diff, b_out, ovf, zero);
            check($sformatf("diff_id%0d", e.id), diff, e.diff);
            check($sformatf("flags_id%0d", e.id), 64'({b_out, ovf, zero}), 64'({e.bout, e.ovf, e.zero}));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_diff  = diff;
        prev_flags = {b_out, ovf, zero};
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    vec_t vecs[9];
    exp_t e;
    int   lat;
    logic found;
    logic [63:0] ra;
    logic [63:0] rb;

    vecs[0] = '{64'h0000_0000_0000_000A, 64'h3, 1'b0, 64'h7, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'h0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{64'h0001_0000_0000_0000, 64'h1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{64'h0000_0000_0001_0000, 64'h0, 1'b1, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    b_in      = 1'b0;
    out_ready = 1'b1;

    // Reset, then idle.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_diff", diff, 64'd0);
    check("rst_flags", 64'({b_out, ovf, zero}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("idle_state", 64'({out_valid, in_ready}), 64'b01);
      check("idle_diff", diff, 64'd0);
    end

    // Latency of a single accepted operand.
    e = '{64'h7, 1'b0, 1'b0, 1'b0, 1};
    send(64'hA, 64'h3, 1'b0, e);
    lat   = 0;
    found = 1'b0;
    while (!found && lat < 20) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    check("latency_edges", 64'(lat), 64'd4);
    @(posedge clk);
    #1;
    drain();

    // Directed vector table, sent back to back.
    for (int i = 0; i < 9; i++) begin
      e = '{vecs[i].diff, vecs[i].bout, vecs[i].ovf, vecs[i].zero, 10 + i};
      send(vecs[i].a, vecs[i].b, vecs[i].bin, e);
    end
    drain();

    // Streaming: out_ready is low for cycles 6-9.
    stall_cycles = 0;
    fork
      begin
        for (int i = 1; i <= 8; i++) begin
          e = '{64'(i) * 64'h1_0000_0000, 1'b0, 1'b0, 1'b0, 100 + i};
          send(64'(i) * 64'h1_0000_0001, 64'(i), 1'b0, e);
        end
      end
      begin
        for (int c = 0; c < 12; c++) begin
          if (c == 6)  out_ready = 1'b0;
          if (c == 10) out_ready = 1'b1;
          @(posedge clk);
          #1;
        end
      end
    join
    drain();
    check("stream_stall_cycles", 64'(stall_cycles), 64'd4);

    // Random operands under random backpressure, checked against the model.
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          ra = {$urandom, $urandom};
          rb = {$urandom, $urandom};
          if (i == 0) rb = ra;
          e = model(ra, rb, 1'(i % 2), 300 + i);
          send(ra, rb, 1'(i % 2), e);
        end
      end
      begin
        for (int c = 0; c < 30; c++) begin
          out_ready = 1'($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with operands in flight. The third operand arrives together with reset.
    send(64'h55, 64'h11, 1'b0, '{64'h44, 1'b0, 1'b0, 1'b0, 200});
    send(64'h66, 64'h22, 1'b0, '{64'h44, 1'b0, 1'b0, 1'b0, 201});
    in_valid = 1'b1;
    a        = 64'h77;
    b        = 64'h33;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("midrst_diff", diff, 64'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // The pipeline still works after the mid-flight reset.
    send(64'h1_0000, 64'h1, 1'b0, '{64'hFFFF, 1'b0, 1'b0, 1'b0, 400});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_subtractor.md
Name: pipelined_subtractor

Overview:
- Multi-cycle 64-bit subtractor: diff = a - b - b_in.
- It is the inverse-direction companion to the team's combinational 64-bit adder.
- The borrow ripples through registered 16-bit slices, one slice per stage. This gives a 4-cycle latency with a throughput of one result per clock.
- Sits in the ALU datapath behind a valid/ready handshake, so the downstream stage can apply backpressure.

Parameters:
- WIDTH, 64, operand and result width in bits.
- SLICE, 16, bits resolved per pipeline stage. WIDTH must be an integer multiple of SLICE.
- STAGES, WIDTH/SLICE (4), pipeline depth. Derived; do not override.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands on a, b, b_in are valid this cycle.
- in_ready  output  1  block accepts an operand set this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- b_in  input  1  borrow in.
- out_valid  output  1  result outputs hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- diff  output  WIDTH  a - b - b_in, modulo 2^WIDTH.
- b_out  output  1  borrow out; 1 iff unsigned a < b + b_in.
- ovf  output  1  signed overflow: a[MSB]!=b[MSB] and diff[MSB]!=a[MSB].
- zero  output  1  diff == 0.

Behaviour:
- Reset (rst=1 at an edge):
  - All stage valid bits cleared.
  - out_valid=0; diff=0; b_out=0; ovf=0; zero=0.
  - rst has priority over every other event, and an operand presented in the same cycle is dropped.
  - Reset mid-operation discards all in-flight results; none appears afterwards.
- Stall rule:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, a combinational function of registered out_valid and the out_ready input.
  - When stall=1, every stage register holds its value, including data, valid and partial result.
  - When stall=0, all stages advance one position per clock. Bubbles (valid=0) advance like data.
- Acceptance: an operand set is captured when in_valid & in_ready at the edge. If in_valid=0 while not stalled, a bubble enters stage 0.
- Stage k (k = 0..STAGES-1):
  - Computes diff slice [k*SLICE +: SLICE] from the carried a and b slices and the borrow registered by stage k-1.
  - Stage 0 uses b_in as its borrow.
  - Registers the slice result, the borrow-out, the unresolved upper operand slices, and the already-resolved lower diff slices.
  - Upper slices of a and b not yet consumed must travel with the data. The a and b MSBs are kept for the ovf computation.
- Output register: the final stage drives diff, b_out, ovf and zero directly from registers.
- Latency: 4 clock edges from acceptance to out_valid=1 with no stall. Example: accepted at edge N, visible after edge N+4.
- Throughput: back-to-back acceptance every cycle with out_ready held at 1. Results emerge in order, with no loss and no duplication.
- Holding under backpressure: while out_valid=1 and out_ready=0, outputs stay constant and in_ready=0.
- Simultaneous events: with out_valid=1, out_ready=1 and in_valid=1 in the same cycle, the result is consumed and the new operand enters. No bubble is inserted.
- Wrap-around: arithmetic is modulo 2^WIDTH. 0 - 1 gives all-ones with b_out=1.
- No X propagation: outputs are defined after reset regardless of operand values.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 for 10 cycles. Required: out_valid=0, diff=0, in_ready=1 throughout.
- Basic subtract: a=0x0000_0000_0000_000A, b=0x3, b_in=0. Required: 4 cycles later diff=0x7, b_out=0, ovf=0, zero=0.
- Borrow chain across all slices: a=0x0, b=0x0, b_in=1. Required: diff=0xFFFF_FFFF_FFFF_FFFF, b_out=1. Also a=0x0001_0000_0000_0000, b=0x1, b_in=0 gives diff=0x0000_FFFF_FFFF_FFFF, b_out=0.
- Signed overflow and zero:
  - a=0x8000_0000_0000_0000, b=0x1 gives diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
  - a=b=0x1234_5678_9ABC_DEF0 gives diff=0, zero=1, b_out=0.
- Streaming with backpressure: 8 back-to-back operands a=i*0x1_0000_0001, b=i (i=1..8). Hold out_ready=0 for cycles 6-9, then 1. Required:
  - All 8 results emerge in order with diff=i*0x1_0000_0000.
  - Outputs stay stable during the stall, and in_ready=0 during the stall.
- Reset mid-operation: accept 3 operands, assert rst on the 2nd cycle after the first acceptance. Required: out_valid stays 0 for 6 following cycles with in_valid=0; no stale result appears.
